// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
//   pll_state_e      : sequencer state encoding (2-bit)
//   *_DEF            : default parameter values (27 MHz input clock)
//   phase_cnt_width(): width of the single phase counter
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned PLL_RST_CYCLES_DEF = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF   = 27000;
  localparam int unsigned STABLE_CYCLES_DEF  = 2700;
  localparam int unsigned CNT_W_DEF          = 8;

  // The counter only has to reach (largest limit - 1).
  function automatic int unsigned phase_cnt_width(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-facing and downstream-facing signals of the reset sequencer.
//   lock_async    : PLL LOCK, asynchronous to clkin
//   pll_reset     : PLL RESET, active high
//   rst_out_n     : downstream reset, active low
//   ready         : high while the sequencer is in RUN
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   retry_cnt     : saturating count of lock timeouts
//   timeout_pulse : one-cycle pulse per lock timeout
// master = sequencer, slave = PLL wrapper / downstream consumer.
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             lock_async;
  logic             pll_reset;
  logic             rst_out_n;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] retry_cnt;
  logic             timeout_pulse;

  modport master (
    input  lock_async,
    output pll_reset, rst_out_n, ready, lock_loss_cnt, retry_cnt, timeout_pulse
  );

  modport slave (
    output lock_async,
    input  pll_reset, rst_out_n, ready, lock_loss_cnt, retry_cnt, timeout_pulse
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchronizer, synchronous active-low reset to 0.
//   clk_i  : destination clock
//   rst_ni : synchronous reset, active low
//   d_i    : asynchronous input
//   q_o    : synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RESET, waits for lock (with timeout/retry),
// qualifies lock for STABLE_CYCLES and then releases the downstream reset.
// Any lock loss in RUN restarts the whole sequence.
//   clkin  : 27 MHz input clock (only clock)
//   resetn : synchronous active-low reset
//   bus    : sequencer side of pll_reset_sequencer_if (see interface file)
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input logic                   clkin,
  input logic                   resetn,
  pll_reset_sequencer_if.master bus
);
  localparam int unsigned PH_W =
    phase_cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [PH_W-1:0] RST_LAST = PH_W'(PLL_RST_CYCLES - 1);
  localparam logic [PH_W-1:0] TMO_LAST = PH_W'(LOCK_TIMEOUT - 1);
  localparam logic [PH_W-1:0] STB_LAST = PH_W'(STABLE_CYCLES - 1);

  pll_state_e       state_q;
  logic [PH_W-1:0]  phase_q;
  logic             pll_reset_q;
  logic             rst_out_n_q;
  logic             ready_q;
  logic [CNT_W-1:0] loss_q;
  logic [CNT_W-1:0] retry_q;
  logic             tmo_q;
  logic             lock_s;
  logic             sync_rst_n;

  // The synchronizer is held clear while the PLL is in reset, so a stale
  // LOCK from before the reset pulse can never qualify the new attempt.
  assign sync_rst_n = resetn && (state_q != PLL_RST);

  sync_2ff u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (sync_rst_n),
    .d_i    (bus.lock_async),
    .q_o    (lock_s)
  );

  // Outputs are updated together with the state they belong to, so they
  // change on the same edge as the state transition.
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q     <= PLL_RST;
      phase_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
      loss_q      <= '0;
      retry_q     <= '0;
      tmo_q       <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        PLL_RST: begin
          if (phase_q == RST_LAST) begin
            state_q     <= WAIT_LOCK;
            phase_q     <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            phase_q <= '0;
          end else if (phase_q == TMO_LAST) begin
            state_q     <= PLL_RST;
            phase_q     <= '0;
            pll_reset_q <= 1'b1;
            tmo_q       <= 1'b1;
            if (retry_q != '1) retry_q <= retry_q + 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            phase_q <= '0;
          end else if (phase_q == STB_LAST) begin
            state_q     <= RUN;
            phase_q     <= '0;
            rst_out_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q     <= PLL_RST;
            phase_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
            if (loss_q != '1) loss_q <= loss_q + 1'b1;
          end
        end
        default: begin
          state_q     <= PLL_RST;
          phase_q     <= '0;
          pll_reset_q <= 1'b1;
          rst_out_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_reset     = pll_reset_q;
  assign bus.rst_out_n     = rst_out_n_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.timeout_pulse = tmo_q;
endmodule
